// File: rtl/piano_key_scanner_if.sv
// piano_key_scanner_if: raw button inputs and decoded note/octave outputs of the key scanner
// ports: key_raw[6:0] (C..B), oct_up_raw, oct_dn_raw in; c..b, up, down, note_valid out
interface piano_key_scanner_if;
   logic [6:0] key_raw;
   logic       oct_up_raw;
   logic       oct_dn_raw;
   logic       c, d, e, f, g, a, b;
   logic       up;
   logic       down;
   logic       note_valid;
   modport master (output key_raw, oct_up_raw, oct_dn_raw,
                   input c, d, e, f, g, a, b, up, down, note_valid);
   modport slave  (input key_raw, oct_up_raw, oct_dn_raw,
                   output c, d, e, f, g, a, b, up, down, note_valid);
endinterface

// File: rtl/piano_key_scanner.sv
// piano_key_scanner: synchronizes and debounces 7 note keys plus octave up/down buttons, drives one-hot note and octave state
// ports: clk, rst (sync, active-high); bus (slave): raw buttons in, c..b/up/down/note_valid out
module piano_key_scanner #(
   parameter int DB_CYCLES = 4,
   parameter int CNT_W     = 16
) (
   input logic               clk,
   input logic               rst,
   piano_key_scanner_if.slave bus
);
   localparam logic [1:0]       LOW    = 2'd0;
   localparam logic [1:0]       MID    = 2'd1;
   localparam logic [1:0]       HIGH   = 2'd2;
   localparam logic [CNT_W-1:0] DB_LIM = CNT_W'(DB_CYCLES);
   logic [8:0] w_raw, r_s1, r_s2, w_db;
   logic [1:0] r_db_q;
   logic [6:0] r_note, w_sel;
   logic [1:0] r_oct, w_oct_nxt;
   logic       w_up_rise, w_dn_rise;
   assign w_raw = {bus.oct_dn_raw, bus.oct_up_raw, bus.key_raw};
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= w_raw;
         r_s2 <= r_s1;
      end
   end
   for (genvar i = 0; i < 9; i++) begin : g_db
      logic [CNT_W-1:0] r_cnt;
      logic             r_lvl;
      always_ff @(posedge clk) begin
         if (rst) begin
            r_cnt <= '0;
            r_lvl <= 1'b0;
         end else if (r_s2[i] == r_lvl) begin
            r_cnt <= '0;
         end else if (r_cnt + 1'b1 == DB_LIM) begin
            r_lvl <= r_s2[i];
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
      assign w_db[i] = r_lvl;
   end
   // isolate lowest set bit so C beats D beats ... B
   assign w_sel     = w_db[6:0] & (~w_db[6:0] + 7'd1);
   assign w_up_rise = w_db[7] & ~r_db_q[0];
   assign w_dn_rise = w_db[8] & ~r_db_q[1];
   always_comb begin
      w_oct_nxt = (w_up_rise & ~w_dn_rise) ? ((r_oct == LOW) ? MID : HIGH) :
                  (w_dn_rise & ~w_up_rise) ? ((r_oct == HIGH) ? MID : LOW) : r_oct;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_note <= '0;
         r_db_q <= '0;
         r_oct  <= MID;
      end else begin
         r_note <= w_sel;
         r_db_q <= w_db[8:7];
         r_oct  <= w_oct_nxt;
      end
   end
   assign {bus.b, bus.a, bus.g, bus.f, bus.e, bus.d, bus.c} = r_note;
   assign bus.note_valid = |r_note;
   assign bus.up         = (r_oct == HIGH);
   assign bus.down       = (r_oct == LOW);
endmodule

// File: tb/tb_piano_key_scanner.sv
// tb_piano_key_scanner: directed and randomized checks of piano_key_scanner against a window-based reference model
module tb_piano_key_scanner;
   localparam int DB = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   piano_key_scanner_if bus ();
   piano_key_scanner #(.DB_CYCLES(DB), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   logic [8:0] m_d1, m_d2, m_db, m_dbp;
   logic [8:0] m_win[$];
   logic [6:0] m_note;
   int         m_oct;
   // a level flips once the last DB synced samples all disagree with it
   always @(posedge clk) begin : model
      logic [8:0] raw, flip;
      logic       up_r, dn_r;
      raw = {bus.oct_dn_raw, bus.oct_up_raw, bus.key_raw};
      if (rst) begin
         m_d1 = '0; m_d2 = '0; m_db = '0; m_dbp = '0;
         m_win.delete();
         m_note = '0;
         m_oct = 1;
      end else begin
         m_win.push_back(m_d2);
         if (m_win.size() > DB) void'(m_win.pop_front());
         flip = '0;
         if (m_win.size() == DB)
            for (int j = 0; j < 9; j++) begin
               flip[j] = 1'b1;
               foreach (m_win[k]) if (m_win[k][j] == m_db[j]) flip[j] = 1'b0;
            end
         m_note = '0;
         for (int j = 6; j >= 0; j--) if (m_db[j]) m_note = 7'(1 << j);
         up_r = m_db[7] & ~m_dbp[7];
         dn_r = m_db[8] & ~m_dbp[8];
         if (up_r && !dn_r) m_oct = (m_oct < 2) ? m_oct + 1 : 2;
         if (dn_r && !up_r) m_oct = (m_oct > 0) ? m_oct - 1 : 0;
         m_dbp = m_db;
         m_db  = m_db ^ flip;
         m_d2  = m_d1;
         m_d1  = raw;
      end
   end
   function automatic logic [9:0] dut_out();
      return {bus.note_valid, bus.down, bus.up, bus.b, bus.a, bus.g, bus.f, bus.e, bus.d, bus.c};
   endfunction
   function automatic logic [9:0] exp_out();
      return {|m_note, m_oct == 0, m_oct == 2, m_note};
   endfunction
   task automatic test_reset();
      rst = 1'b1;
      bus.key_raw = '0; bus.oct_up_raw = 1'b0; bus.oct_dn_raw = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests++;
         if (dut_out() !== 10'b0) begin
            fails++;
            $display("FAIL reset cyc%0d got %b want %b", i, dut_out(), 10'b0);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tests++;
         if (dut_out() !== 10'b0) begin
            fails++;
            $display("FAIL post_reset cyc%0d got %b want %b", i, dut_out(), 10'b0);
         end
      end
   endtask
   task automatic test_latency();
      logic [9:0] want;
      bus.key_raw = 7'b0000100;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         want = (k >= DB + 3) ? 10'b1_00_0000100 : 10'b0;
         tests++;
         if (dut_out() !== want || exp_out() !== want) begin
            fails++;
            $display("FAIL latency edge%0d got %b model %b want %b", k, dut_out(), exp_out(), want);
         end
      end
      bus.key_raw = '0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         want = (k >= DB + 3) ? 10'b0 : 10'b1_00_0000100;
         tests++;
         if (dut_out() !== want) begin
            fails++;
            $display("FAIL latency_release edge%0d got %b want %b", k, dut_out(), want);
         end
      end
   endtask
   task automatic test_glitch();
      bus.key_raw = 7'b0000001;
      repeat (3) @(negedge clk);
      bus.key_raw = '0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         tests++;
         if (dut_out() !== 10'b0 || exp_out() !== 10'b0) begin
            fails++;
            $display("FAIL glitch cyc%0d got %b model %b want %b", k, dut_out(), exp_out(), 10'b0);
         end
      end
   endtask
   task automatic test_priority();
      logic [9:0] want;
      bus.key_raw = 7'b1001010;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         want = (k >= DB + 3) ? 10'b1_00_0000010 : 10'b0;
         tests++;
         if (dut_out() !== want) begin
            fails++;
            $display("FAIL priority_dfb edge%0d got %b want %b", k, dut_out(), want);
         end
      end
      bus.key_raw = 7'b1001000;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         want = (k >= DB + 3) ? 10'b1_00_0001000 : 10'b1_00_0000010;
         tests++;
         if (dut_out() !== want) begin
            fails++;
            $display("FAIL priority_fb edge%0d got %b want %b", k, dut_out(), want);
         end
      end
      bus.key_raw = '0;
      repeat (10) @(negedge clk);
   endtask
   task automatic test_octave();
      logic [1:0] want_ud[5] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10};
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int p = 0; p < 5; p++) begin
         if (p < 3) bus.oct_up_raw = 1'b1; else bus.oct_dn_raw = 1'b1;
         for (int k = 0; k < 16; k++) begin
            if (k == 8) begin
               bus.oct_up_raw = 1'b0;
               bus.oct_dn_raw = 1'b0;
            end
            @(negedge clk);
            tests++;
            if (dut_out() !== exp_out()) begin
               fails++;
               $display("FAIL octave press%0d cyc%0d got %b model %b", p, k, dut_out(), exp_out());
            end
         end
         tests++;
         if ({bus.down, bus.up} !== want_ud[p]) begin
            fails++;
            $display("FAIL octave_state press%0d got %b want %b", p, {bus.down, bus.up}, want_ud[p]);
         end
      end
   endtask
   task automatic test_simultaneous();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bus.oct_up_raw = 1'b1;
      bus.oct_dn_raw = 1'b1;
      for (int k = 0; k < 16; k++) begin
         if (k == 8) begin
            bus.oct_up_raw = 1'b0;
            bus.oct_dn_raw = 1'b0;
         end
         @(negedge clk);
         tests++;
         if ({bus.down, bus.up} !== 2'b00 || exp_out() !== 10'b0) begin
            fails++;
            $display("FAIL simultaneous cyc%0d got %b model %b want 00", k, {bus.down, bus.up}, exp_out());
         end
      end
   endtask
   task automatic test_reset_mid();
      logic [9:0] want;
      bus.key_raw = 7'b0010000;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         tests++;
         if (dut_out() !== 10'b0) begin
            fails++;
            $display("FAIL reset_mid_hold cyc%0d got %b want %b", k, dut_out(), 10'b0);
         end
      end
      rst = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         want = (k >= DB + 3) ? 10'b1_00_0010000 : 10'b0;
         tests++;
         if (dut_out() !== want) begin
            fails++;
            $display("FAIL reset_mid edge%0d got %b want %b", k, dut_out(), want);
         end
      end
      bus.key_raw = '0;
      repeat (10) @(negedge clk);
   endtask
   task automatic test_random();
      int hold = 0;
      for (int i = 0; i < 1500; i++) begin
         if (hold == 0) begin
            bus.key_raw    = 7'($urandom);
            bus.oct_up_raw = 1'($urandom_range(0, 2) == 0);
            bus.oct_dn_raw = 1'($urandom_range(0, 2) == 0);
            hold = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, DB)) : int'($urandom_range(DB + 1, 3 * DB));
         end
         hold--;
         rst = ($urandom_range(0, 79) == 0);
         @(negedge clk);
         tests++;
         if (dut_out() !== exp_out()) begin
            fails++;
            $display("FAIL random cyc%0d got %b model %b", i, dut_out(), exp_out());
         end
      end
      rst = 1'b0;
   endtask
   initial begin
      bus.key_raw = '0;
      bus.oct_up_raw = 1'b0;
      bus.oct_dn_raw = 1'b0;
      test_reset();
      test_latency();
      test_glitch();
      test_priority();
      test_octave();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
